// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and related blocks.
// Holds the arbiter state encoding, default message terminator and escape byte.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    HOLD   = 2'd2
  } arb_state_e;

  localparam logic [7:0] EOM_DEFAULT     = 8'h0a;
  localparam logic [7:0] ESC_BYTE        = 8'h1b;
  localparam int         TIMEOUT_DEFAULT = 12000;
  localparam int         TMO_W           = 14;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first set request bit after
// i_last, wrapping around; o_any flags that at least one request is present.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N   = 2,
  localparam int IDW = idx_w(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  output logic [IDW-1:0] o_grant,
  output logic           o_any
);

  // Distance 0 is the requester right after i_last; the smallest distance wins.
  always_comb begin
    int w_best;
    int w_dist;
    w_best  = N;
    w_dist  = 0;
    o_grant = '0;
    o_any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + 2 * N - 1 - int'(i_last)) % N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = IDW'(i);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing the uartTxBuf byte input.
// Optional macro TX_ARB_TIMEOUT_EN: forced release after an idle owner timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int         N_REQ          = 2,
  parameter  logic [7:0] EOM_BYTE       = EOM_DEFAULT,
`ifdef TX_ARB_TIMEOUT_EN
  parameter  int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
`endif
  localparam int         IDW            = idx_w(N_REQ)
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ack,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_data_rdy,
  output logic [IDW-1:0]       grant_id,
  output logic                 grant_active
);

  arb_state_e       r_state;
  logic [IDW-1:0]   r_last_grant;
  logic [IDW-1:0]   r_grant_id;
  logic             r_grant_active;
  logic [7:0]       r_tx_data;
  logic             r_tx_data_rdy;
  logic [N_REQ-1:0] r_req_ack;

  logic [IDW-1:0]   w_pick;
  logic             w_any_req;
  logic             w_sel_valid;
  logic [7:0]       w_sel_data;
  logic [N_REQ-1:0] w_ack_vec;

`ifdef TX_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo_cnt;
`endif

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_pick),
    .o_any   (w_any_req)
  );

  // Route the owner's valid/data and build its one-hot ack vector.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_ack_vec   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant_id == IDW'(i)) begin
        w_sel_valid  = req_valid[i];
        w_sel_data   = req_data[i*8 +: 8];
        w_ack_vec[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state        <= IDLE;
      r_last_grant   <= IDW'(N_REQ - 1);
      r_grant_id     <= '0;
      r_grant_active <= 1'b0;
      r_tx_data      <= '0;
      r_tx_data_rdy  <= 1'b0;
      r_req_ack      <= '0;
`ifdef TX_ARB_TIMEOUT_EN
      r_tmo_cnt      <= '0;
`endif
    end else begin
      r_tx_data_rdy <= 1'b0;
      r_req_ack     <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_id     <= w_pick;
            r_grant_active <= 1'b1;
            r_state        <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_sel_valid && !tx_busy) begin
            r_tx_data     <= w_sel_data;
            r_tx_data_rdy <= 1'b1;
            r_req_ack     <= w_ack_vec;
            r_state       <= HOLD;
`ifdef TX_ARB_TIMEOUT_EN
            r_tmo_cnt     <= '0;
          end else if (!w_sel_valid) begin
            // An owner that has gone quiet too long is released without EOM.
            if (r_tmo_cnt == TMO_LAST) begin
              r_tmo_cnt      <= '0;
              r_last_grant   <= r_grant_id;
              r_grant_active <= 1'b0;
              r_state        <= IDLE;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
`endif
          end
        end
        HOLD: begin
          // tx_busy gets this cycle to reflect the write just issued.
          if (r_tx_data == EOM_BYTE) begin
            r_last_grant   <= r_grant_id;
            r_grant_active <= 1'b0;
            r_state        <= IDLE;
          end else begin
            r_state <= LOCKED;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ack      = r_req_ack;
  assign tx_data      = r_tx_data;
  assign tx_data_rdy  = r_tx_data_rdy;
  assign grant_id     = r_grant_id;
  assign grant_active = r_grant_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with two requesters.
// Requester models feed bytes from per-source queues; the scoreboard holds expected bytes.
module tb_uart_tx_arbiter;

  localparam int TIMEOUT = 12000;

  logic        clk;
  logic        resetq;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ack;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_data_rdy;
  logic [0:0]  grant_id;
  logic        grant_active;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         exp_id_q[$];
  logic [7:0] msg_q0[$];
  logic [7:0] msg_q1[$];

  uart_tx_arbiter #(
    .N_REQ    (2),
    .EOM_BYTE (8'h0a)
  ) dut (
    .clk          (clk),
    .resetq       (resetq),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_data_rdy  (tx_data_rdy),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic update_reqs();
    logic [7:0] tmp;
    if (req_ack[0] && msg_q0.size() > 0) tmp = msg_q0.pop_front();
    if (req_ack[1] && msg_q1.size() > 0) tmp = msg_q1.pop_front();
    req_valid[0]   = (msg_q0.size() > 0);
    req_valid[1]   = (msg_q1.size() > 0);
    req_data[7:0]  = (msg_q0.size() > 0) ? msg_q0[0] : 8'h00;
    req_data[15:8] = (msg_q1.size() > 0) ? msg_q1[0] : 8'h00;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    update_reqs();
  endtask

  task automatic do_reset();
    #3;
    resetq    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    msg_q0.delete();
    msg_q1.delete();
    exp_q.delete();
    exp_id_q.delete();
    repeat (3) @(posedge clk);
    #1;
    resetq = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    resetq  = 1'b0;
    tx_busy = 1'b0;
    msg_q0  = {8'h0a};
    msg_q1  = {8'h0a};
    update_reqs();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_data_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b exp 0", tx_data_rdy); end
    checks++; if (req_ack !== 2'b00) begin failures++; $display("FAIL reset_ack: got %b exp 00", req_ack); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h exp 00", tx_data); end
    checks++; if (grant_active !== 1'b0) begin failures++; $display("FAIL reset_active: got %b exp 0", grant_active); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL reset_gid: got %b exp 0", grant_id); end
    resetq = 1'b1;
    cycle();
    checks++; if (grant_active !== 1'b1 || grant_id !== 1'b0) begin
      failures++; $display("FAIL reset_first_grant: got active=%b id=%0d exp active=1 id=0", grant_active, grant_id);
    end
  endtask

  task automatic test_single();
    int start, last_c, eom_c;
    logic [7:0] exp;
    do_reset();
    msg_q0 = {8'h4f, 8'h4b, 8'h0a};
    exp_q  = {8'h4f, 8'h4b, 8'h0a};
    update_reqs();
    start  = cyc;
    last_c = -1;
    eom_c  = -1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (tx_data_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL single_extra: got %h exp none", tx_data);
        end else begin
          exp = exp_q.pop_front();
          if (tx_data !== exp) begin failures++; $display("FAIL single_data: got %h exp %h", tx_data, exp); end
        end
        checks++;
        if ((last_c < 0) ? (cyc - start != 2) : (cyc - last_c != 2)) begin
          failures++; $display("FAIL single_spacing: got %0d exp 2", (last_c < 0) ? cyc - start : cyc - last_c);
        end
        last_c = cyc;
        if (tx_data == 8'h0a) begin
          eom_c = cyc;
          checks++; if (grant_active !== 1'b1) begin failures++; $display("FAIL single_active_eom: got %b exp 1", grant_active); end
        end
      end
      if (eom_c >= 0 && cyc == eom_c + 1) begin
        checks++; if (grant_active !== 1'b0) begin failures++; $display("FAIL single_release: got %b exp 0", grant_active); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_missing: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_contention();
    logic [7:0] exp;
    logic [1:0] exp_ack;
    int         exp_id;
    logic       prev_rdy;
    do_reset();
    msg_q0   = {8'h41, 8'h42, 8'h0a};
    msg_q1   = {8'h63, 8'h64, 8'h0a};
    exp_q    = {8'h41, 8'h42, 8'h0a, 8'h63, 8'h64, 8'h0a};
    exp_id_q = {0, 0, 0, 1, 1, 1};
    update_reqs();
    prev_rdy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (tx_data_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL contention_extra: got %h exp none", tx_data);
        end else begin
          exp     = exp_q.pop_front();
          exp_id  = exp_id_q.pop_front();
          exp_ack = 2'b01 << exp_id;
          if (tx_data !== exp || req_ack !== exp_ack) begin
            failures++; $display("FAIL contention_stream: got data=%h ack=%b exp data=%h ack=%b", tx_data, req_ack, exp, exp_ack);
          end
        end
        checks++; if (prev_rdy) begin failures++; $display("FAIL contention_back_to_back: got 2 strobes exp 1"); end
      end
      prev_rdy = tx_data_rdy;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL contention_missing: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_fairness();
    int   exp_id, owner, prev_owner;
    do_reset();
    msg_q0   = {8'h0a, 8'h0a, 8'h0a, 8'h0a};
    msg_q1   = {8'h0a, 8'h0a, 8'h0a, 8'h0a};
    exp_id_q = {0, 1, 0, 1, 0, 1, 0, 1};
    update_reqs();
    prev_owner = -1;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (req_ack != 2'b00) begin
        owner = req_ack[1] ? 1 : 0;
        checks++;
        if (!$onehot(req_ack)) begin failures++; $display("FAIL fair_onehot: got %b exp one-hot", req_ack); end
        checks++;
        if (exp_id_q.size() == 0) begin
          failures++; $display("FAIL fair_extra: got owner %0d exp none", owner);
        end else begin
          exp_id = exp_id_q.pop_front();
          if (owner != exp_id || grant_id !== 1'(exp_id)) begin
            failures++; $display("FAIL fair_order: got owner=%0d gid=%0d exp %0d", owner, grant_id, exp_id);
          end
        end
        checks++; if (owner == prev_owner) begin failures++; $display("FAIL fair_repeat: got owner %0d twice exp alternate", owner); end
        prev_owner = owner;
      end
    end
    checks++; if (exp_id_q.size() != 0) begin failures++; $display("FAIL fair_missing: got %0d left exp 0", exp_id_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    int         stall_bad;
    do_reset();
    tx_busy = 1'b1;
    msg_q0  = {8'h55, 8'h0a};
    exp_q   = {8'h55, 8'h0a};
    update_reqs();
    cycle();
    checks++; if (grant_active !== 1'b1) begin failures++; $display("FAIL bp_locked: got %b exp 1", grant_active); end
    stall_bad = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (tx_data_rdy !== 1'b0 || req_ack !== 2'b00) stall_bad++;
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall: got %0d strobe cycles exp 0", stall_bad); end
    tx_busy = 1'b0;
    cycle();
    checks++;
    if (tx_data_rdy !== 1'b1 || tx_data !== 8'h55 || req_ack !== 2'b01) begin
      failures++; $display("FAIL bp_release: got rdy=%b data=%h ack=%b exp rdy=1 data=55 ack=01", tx_data_rdy, tx_data, req_ack);
    end
    if (tx_data_rdy) exp = exp_q.pop_front();
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (tx_data_rdy && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++; if (tx_data !== exp) begin failures++; $display("FAIL bp_tail: got %h exp %h", tx_data, exp); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_missing: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    logic       first;
    int         seen;
    do_reset();
    msg_q0 = {8'h41, 8'h42, 8'h0a};
    msg_q1 = {8'h63, 8'h64, 8'h0a};
    update_reqs();
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      cycle();
      if (tx_data_rdy) seen = 1;
    end
    checks++; if (seen == 0 || tx_data !== 8'h41) begin failures++; $display("FAIL rmid_first: got %h exp 41", tx_data); end
    resetq = 1'b0;
    #1;
    checks++;
    if (tx_data_rdy !== 1'b0 || req_ack !== 2'b00 || tx_data !== 8'h00 || grant_active !== 1'b0 || grant_id !== 1'b0) begin
      failures++; $display("FAIL rmid_outputs: got rdy=%b ack=%b data=%h act=%b id=%0d exp all 0",
                           tx_data_rdy, req_ack, tx_data, grant_active, grant_id);
    end
    repeat (2) @(posedge clk);
    #1;
    msg_q0 = {8'h41, 8'h42, 8'h0a};
    msg_q1 = {8'h63, 8'h64, 8'h0a};
    exp_q  = {8'h41, 8'h42, 8'h0a, 8'h63, 8'h64, 8'h0a};
    update_reqs();
    resetq = 1'b1;
    first  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (tx_data_rdy) begin
        if (first) begin
          checks++; if (req_ack !== 2'b01) begin failures++; $display("FAIL rmid_winner: got ack %b exp 01", req_ack); end
          first = 1'b0;
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rmid_extra: got %h exp none", tx_data);
        end else begin
          exp = exp_q.pop_front();
          if (tx_data !== exp) begin failures++; $display("FAIL rmid_stream: got %h exp %h", tx_data, exp); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_missing: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_owner_stall();
    int c0, seen, rel_c, ack1_c;
    do_reset();
    msg_q0 = {8'h41};
    msg_q1 = {8'h63, 8'h0a};
    update_reqs();
    seen = 0;
    c0   = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      cycle();
      if (tx_data_rdy) begin seen = 1; c0 = cyc; end
    end
    checks++; if (seen == 0 || tx_data !== 8'h41) begin failures++; $display("FAIL stall_first: got %h exp 41", tx_data); end
`ifdef TX_ARB_TIMEOUT_EN
    rel_c  = -1;
    ack1_c = -1;
    for (int k = 0; k < TIMEOUT + 20; k++) begin
      cycle();
      if (rel_c < 0 && grant_active === 1'b0) rel_c = cyc;
      if (ack1_c < 0 && req_ack[1] === 1'b1) ack1_c = cyc;
    end
    checks++; if (rel_c != c0 + 1 + TIMEOUT) begin failures++; $display("FAIL timeout_release: got cycle %0d exp %0d", rel_c - c0, 1 + TIMEOUT); end
    checks++; if (ack1_c != c0 + 3 + TIMEOUT) begin failures++; $display("FAIL timeout_regrant: got cycle %0d exp %0d", ack1_c - c0, 3 + TIMEOUT); end
`else
    rel_c  = 0;
    ack1_c = 0;
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (grant_active !== 1'b1 || grant_id !== 1'b0) rel_c++;
      if (req_ack[1] !== 1'b0 || tx_data_rdy !== 1'b0) ack1_c++;
    end
    checks++; if (rel_c != 0) begin failures++; $display("FAIL stall_lock_held: got %0d unlocked cycles exp 0", rel_c); end
    checks++; if (ack1_c != 0) begin failures++; $display("FAIL stall_no_grant: got %0d strobe cycles exp 0", ack1_c); end
`endif
  endtask

  // Sequence and final report
  initial begin
    resetq    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_owner_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single host-bound byte path (the uartTxBuf txdata/txDataValid input) between N_REQ byte sources, e.g. the lab DUT plus a status/echo source.
- Grants are round-robin and locked per message: once granted, a requester owns the path until it sends the end-of-message byte. Lines from different sources therefore never interleave on the serial link.
- Sits between the requesters and uartTxBuf; txBusy is the backpressure input.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- EOM_BYTE, 8'h0a, byte that terminates a message and releases the grant.
- TIMEOUT_CYCLES, 12000, idle cycles in LOCKED before forced release (1 ms at 12 MHz); used only with the optional feature.

Ports:
- clk, input, 1, system clock (PLL core output).
- resetq, input, 1, asynchronous active-low reset.
- req_valid, input, N_REQ, requester i has a byte on req_data[8i+7:8i].
- req_data, input, 8*N_REQ, packed byte per requester; held stable until acked.
- req_ack, output, N_REQ, one-cycle pulse: the byte from requester i was taken.
- tx_busy, input, 1, downstream buffer cannot accept a byte.
- tx_data, output, 8, byte to uartTxBuf.
- tx_data_rdy, output, 1, one-cycle write strobe to uartTxBuf.
- grant_id, output, IDW=$clog2(N_REQ), current owner index.
- grant_active, output, 1, high while a requester owns the path.

Behaviour:
- Reset (resetq low, asynchronous): all outputs are 0; state IDLE; last_grant = N_REQ-1, so requester 0 wins first; timeout counter = 0. Reset mid-message drops the lock, and no partial strobe is emitted.
- States:
  - IDLE: if any req_valid, select the first set bit searching from last_grant+1 with wrap-around. Register grant_id and set grant_active=1, then go LOCKED. One arbitration cycle, no byte moved.
  - LOCKED: if req_valid[grant_id] and !tx_busy, register tx_data=byte, tx_data_rdy=1, req_ack[grant_id]=1 (all in the same cycle, one-cycle pulses), then go HOLD.
  - HOLD: one cycle with no strobe, giving tx_busy time to reflect the write. If the sent byte == EOM_BYTE: last_grant<=grant_id, grant_active<=0, go IDLE. Otherwise return to LOCKED.
- Latency: request to first strobe is 2 cycles from IDLE. Sustained throughput is at most 1 byte per 2 cycles, further limited by tx_busy.
- Non-granted req_valid is ignored while locked; those requesters are never acked.
- If the owner deasserts req_valid mid-message, the lock persists (no release without EOM, except via the optional feature).
- If tx_busy is high in LOCKED, wait with no strobe and no ack; data is not sampled.
- req_ack and tx_data_rdy are never high on two consecutive cycles.
- With N_REQ=1 the arbiter degenerates to a pass-through with HOLD spacing.
- At most one req_ack bit is set in any cycle.

Optional Feature:
- Macro: TX_ARB_TIMEOUT_EN.
- Defined:
  - A 14-bit counter increments each LOCKED cycle in which req_valid[grant_id] is low, and clears on any strobe or on leaving LOCKED.
  - When the counter reaches TIMEOUT_CYCLES-1, the block releases as if EOM had been sent: last_grant<=grant_id, go IDLE, no byte emitted.
- Not defined: no counter; the lock is held until EOM_BYTE.

Decomposition:
- Shared package uart_arb_pkg:
  - state enum {IDLE, LOCKED, HOLD};
  - EOM default constant 8'h0a;
  - ESC constant 8'h1b (shared with the reset generator);
  - timeout default.
- One natural sub-module: rr_pick (combinational round-robin priority selector: req vector + last_grant -> grant index + any_req). It is reusable by other arbiters.

Test Plan:
- Single source: req0 sends "OK\n" (8'h4f, 8'h4b, 8'h0a), tx_busy=0. Expect 3 strobes with bytes in order, spaced 2 cycles, first strobe 2 cycles after req_valid. grant_active falls the cycle after HOLD of 8'h0a.
- Contention: req0 "AB\n" and req1 "cd\n" both asserted at once after reset. Expect all of req0's message first, then all of req1's. tx stream = 41 42 0a 63 64 0a, with no interleave.
- Fairness: both always requesting 1-byte messages 8'h0a. Grants alternate 0,1,0,1; req_ack never hits the same requester twice in a row.
- Backpressure: tx_busy held high for 10 cycles while LOCKED with a byte pending. Expect no strobe and no ack during those cycles; the strobe comes 1 cycle after tx_busy falls.
- Reset mid-message: deassert resetq after req0 has sent 8'h41 of "AB\n". Outputs are 0 immediately; after release, req1 pending wins? No: last_grant resets to N_REQ-1, so req0 wins first.
- TX_ARB_TIMEOUT_EN: req0 sends 8'h41, then drops req_valid while req1 waits. Release occurs after exactly TIMEOUT_CYCLES idle cycles, then req1 is granted. Without the macro, req1 is never granted.
